// File: rtl/pulse_sync_bank.sv
// pulse_sync_bank
//   Carries CHANNELS independent single-cycle event strobes from clk_in to
//   clk_out. Each channel uses a toggle request / acknowledge handshake and a
//   pending-event counter, so bursts that arrive faster than one round trip
//   are queued rather than lost.
//
// Ports
//   reset      in   async, active-high; clears both clock domains
//   clk_out    in   destination clock
//   clk_in     in   source clock
//   pulse_in   in   [CHANNELS] clk_in; each high cycle is one event
//   ovf_clr    in   clk_in one-cycle strobe; clears all overflow bits
//   busy       out  [CHANNELS] clk_in; transfer in flight or events pending
//   overflow   out  [CHANNELS] clk_in, sticky; an event was dropped
//   pulse_out  out  [CHANNELS] clk_out; one high cycle per delivered event
//
// Handshake (per channel): the source owns r_req_tgl, the destination owns
//   r_req_h. A request is outstanding while r_req_tgl differs from its
//   synchronised acknowledge; the source flips r_req_tgl to post one event
//   only while they are equal. The destination emits one pulse when its
//   synchronised copy of r_req_tgl changes, and r_req_h (the history flop
//   of that copy) is returned as the acknowledge. Only these two flops cross
//   between domains.

`timescale 1ps/1ps

module pulse_sync_bank #(
   parameter int CHANNELS    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int PEND_W      = 3
) (
   input  logic                reset,
   input  logic                clk_out,
   input  logic                clk_in,
   input  logic [CHANNELS-1:0] pulse_in,
   input  logic                ovf_clr,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] overflow,
   output logic [CHANNELS-1:0] pulse_out
);

   localparam logic [PEND_W-1:0] PEND_MAX  = '1;
   localparam logic [PEND_W-1:0] PEND_ZERO = '0;
   localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

   // ---------------- source domain (clk_in) ----------------
   logic [CHANNELS-1:0] r_req_tgl;
   logic [CHANNELS-1:0] r_ack_sync [SYNC_STAGES];
   logic [PEND_W-1:0]   r_pend     [CHANNELS];
   logic [CHANNELS-1:0] r_ovf;
   logic [CHANNELS-1:0] r_busy;

   logic [CHANNELS-1:0] w_ack_s;
   logic [CHANNELS-1:0] w_ack_s_next;
   logic [CHANNELS-1:0] w_idle;
   logic [CHANNELS-1:0] w_issue;
   logic [CHANNELS-1:0] w_drop;
   logic [CHANNELS-1:0] w_req_tgl_next;
   logic [CHANNELS-1:0] w_busy_next;
   logic [PEND_W-1:0]   w_pend_next [CHANNELS];

   // ---------------- destination domain (clk_out) ----------------
   logic [CHANNELS-1:0] r_req_sync [SYNC_STAGES];
   logic [CHANNELS-1:0] r_req_h;
   logic [CHANNELS-1:0] r_pulse_out;
   logic [CHANNELS-1:0] w_req_d;

   assign w_ack_s      = r_ack_sync[SYNC_STAGES-1];
   // Value the acknowledge synchroniser will present after this edge; lets
   // busy be registered yet line up with the state it describes.
   assign w_ack_s_next = r_ack_sync[SYNC_STAGES-2];
   assign w_req_d      = r_req_sync[SYNC_STAGES-1];

   always_comb begin
      w_idle         = ~(r_req_tgl ^ w_ack_s);
      w_issue        = '0;
      w_drop         = '0;
      w_busy_next    = '0;
      w_req_tgl_next = r_req_tgl;
      for (int i = 0; i < CHANNELS; i++) begin
         w_pend_next[i] = r_pend[i];
         w_issue[i]     = w_idle[i] & ((r_pend[i] != PEND_ZERO) | pulse_in[i]);
         w_drop[i]      = pulse_in[i] & ~w_issue[i] & (r_pend[i] == PEND_MAX);
         // An accepted pulse that is not issued this cycle is queued; an
         // issue without a new pulse drains one queued event.
         if (pulse_in[i] && !w_issue[i] && !w_drop[i]) begin
            w_pend_next[i] = r_pend[i] + PEND_ONE;
         end else if (!pulse_in[i] && w_issue[i]) begin
            w_pend_next[i] = r_pend[i] - PEND_ONE;
         end
         w_req_tgl_next[i] = r_req_tgl[i] ^ w_issue[i];
         w_busy_next[i]    = (w_req_tgl_next[i] != w_ack_s_next[i]) |
                             (w_pend_next[i] != PEND_ZERO);
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         r_req_tgl <= '0;
         r_ovf     <= '0;
         r_busy    <= '0;
         for (int s = 0; s < SYNC_STAGES; s++) begin
            r_ack_sync[s] <= '0;
         end
         for (int i = 0; i < CHANNELS; i++) begin
            r_pend[i] <= '0;
         end
      end else begin
         r_req_tgl     <= w_req_tgl_next;
         r_busy        <= w_busy_next;
         // A drop in the same cycle as ovf_clr keeps the bit set.
         r_ovf         <= (r_ovf & ~{CHANNELS{ovf_clr}}) | w_drop;
         r_ack_sync[0] <= r_req_h;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_ack_sync[s] <= r_ack_sync[s-1];
         end
         for (int i = 0; i < CHANNELS; i++) begin
            r_pend[i] <= w_pend_next[i];
         end
      end
   end

   always_ff @(posedge clk_out or posedge reset) begin
      if (reset) begin
         r_req_h     <= '0;
         r_pulse_out <= '0;
         for (int s = 0; s < SYNC_STAGES; s++) begin
            r_req_sync[s] <= '0;
         end
      end else begin
         r_req_sync[0] <= r_req_tgl;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            r_req_sync[s] <= r_req_sync[s-1];
         end
         r_req_h     <= w_req_d;
         r_pulse_out <= w_req_d ^ r_req_h;
      end
   end

   assign busy      = r_busy;
   assign overflow  = r_ovf;
   assign pulse_out = r_pulse_out;

endmodule
